// File: rtl/program_sequencer_if.sv
// rtl/program_sequencer_if.sv - instruction memory, register read and datapath bus of the sequencer
interface program_sequencer_if;
   logic [7:0]  address;
   logic [7:0]  selectOut;
   logic [15:0] instruction;
   logic [3:0]  condRegSel;
   logic [7:0]  condValue;
   logic        execValid;
   logic [3:0]  opcode;
   logic [3:0]  fieldA;
   logic [3:0]  fieldB;
   logic [3:0]  fieldC;

   modport master (
      output address, selectOut, condRegSel, execValid,
      output opcode, fieldA, fieldB, fieldC,
      input  instruction, condValue
   );

   modport slave (
      input  address, selectOut, condRegSel, execValid,
      input  opcode, fieldA, fieldB, fieldC,
      output instruction, condValue
   );
endinterface

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - two-cycle fetch/execute program sequencer with jump, halt and conditional halt
module program_sequencer #(
   parameter int MAX_STEPS = 4096
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [7:0]          programSelect,
   program_sequencer_if.master bus,
   output logic                running,
   output logic                halted,
   output logic                fault,
   output logic [15:0]         instrCount
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      EXEC   = 2'd2,
      HALTED = 2'd3
   } seqState;

   seqState     state;
   seqState     nextState;
   logic [7:0]  pc;
   logic [15:0] ir;
   logic [7:0]  selectReg;
   logic [3:0]  irOp;
   logic [8:0]  pcNext;
   logic [15:0] countNext;
   logic        pcWrite;
   logic        stopReq;
   logic        overrun;
   logic        limitHit;
   logic        acceptStart;

   assign irOp = ir[15:12];

   // Decode of the held instruction; only consumed while in EXEC.
   always_comb begin
      pcNext  = {1'b0, pc} + 9'd1;
      pcWrite = 1'b0;
      stopReq = 1'b0;
      case (irOp)
         4'hD: begin
            pcNext  = {1'b0, ir[7:0]};
            pcWrite = 1'b1;
         end
         4'hE: stopReq = 1'b1;
         4'hF: begin
            if (bus.condValue == 8'd0) stopReq = 1'b1;
            else                        pcWrite = 1'b1;
         end
         default: pcWrite = 1'b1;
      endcase
   end

   assign countNext   = (instrCount == 16'hFFFF) ? instrCount : instrCount + 16'd1;
   assign limitHit    = {16'd0, countNext} >= 32'(MAX_STEPS);
   assign overrun     = pcWrite && (pcNext[8:7] != 2'b00);
   assign acceptStart = start && (state == IDLE || state == HALTED);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE, HALTED: if (start) nextState = FETCH;
         FETCH:        nextState = EXEC;
         EXEC:         nextState = (stopReq || overrun || limitHit) ? HALTED : FETCH;
         default:      nextState = IDLE;
      endcase
   end

   always_comb begin
      running       = (state == FETCH) || (state == EXEC);
      halted        = (state == HALTED);
      bus.execValid = (state == EXEC) && (irOp <= 4'hC);
   end

   // An overrunning PC keeps its old value; the fault flag records the event.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc         <= 8'd0;
         ir         <= 16'd0;
         selectReg  <= 8'd0;
         instrCount <= 16'd0;
         fault      <= 1'b0;
      end else begin
         if (acceptStart) begin
            selectReg  <= programSelect;
            pc         <= 8'd0;
            instrCount <= 16'd0;
            fault      <= 1'b0;
         end
         if (state == FETCH) ir <= bus.instruction;
         if (state == EXEC) begin
            instrCount <= countNext;
            if (pcWrite && !overrun) pc <= pcNext[7:0];
            if (overrun || limitHit) fault <= 1'b1;
         end
      end
   end

   assign bus.address    = pc;
   assign bus.selectOut  = selectReg;
   assign bus.condRegSel = ir[3:0];
   assign bus.opcode     = ir[15:12];
   assign bus.fieldA     = ir[11:8];
   assign bus.fieldB     = ir[7:4];
   assign bus.fieldC     = ir[3:0];
endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - randomized self-checking bench for program_sequencer
module tb_program_sequencer;
   localparam int STEPS = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  programSelect = 8'd0;
   logic        running;
   logic        halted;
   logic        fault;
   logic [15:0] instrCount;

   program_sequencer_if bus();

   logic [15:0] mem [0:3][0:255];
   logic [7:0]  regs [0:15];

   assign bus.instruction = mem[bus.selectOut[1:0]][bus.address];
   assign bus.condValue   = regs[bus.condRegSel];

   program_sequencer #(.MAX_STEPS(STEPS)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .programSelect(programSelect),
      .bus(bus.master),
      .running(running),
      .halted(halted),
      .fault(fault),
      .instrCount(instrCount)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   logic [31:0] expExecSig, expFetchSig, gotExecSig, gotFetchSig;
   int          expCount, expCycles, haltCyc;
   logic [7:0]  expPc;
   logic        expFault;
   bit          sawHalt;

   // Reference: walk the program instruction by instruction, two cycles each.
   task automatic model(input logic [7:0] sel);
      int pc = 0;
      int cnt = 0;
      int npc;
      int op;
      bit stop;
      logic [15:0] ins;
      expExecSig = 0;
      expFetchSig = 0;
      expFault = 1'b0;
      for (int guard = 0; guard < 70000; guard++) begin
         ins = mem[sel[1:0]][pc];
         expFetchSig = expFetchSig * 33 + 32'(pc);
         if (cnt < 65535) cnt++;
         op = int'(ins[15:12]);
         stop = 1'b0;
         npc = pc + 1;
         if (op <= 12) expExecSig = expExecSig * 33 + {16'(2 * cnt), ins};
         else if (op == 13) npc = int'(ins[7:0]);
         else if (op == 14) stop = 1'b1;
         else if (regs[ins[3:0]] == 8'd0) stop = 1'b1;
         if (!stop && npc > 127) begin
            expFault = 1'b1;
            stop = 1'b1;
         end else if (!stop) begin
            pc = npc;
         end
         if (cnt >= STEPS) begin
            expFault = 1'b1;
            stop = 1'b1;
         end
         if (stop) begin
            expCount = cnt;
            expPc = 8'(pc);
            expCycles = 2 * cnt + 1;
            break;
         end
      end
   endtask

   task automatic run_prog(input logic [7:0] sel, input bit noisy);
      int cyc;
      model(sel);
      gotExecSig = 0;
      gotFetchSig = 0;
      sawHalt = 1'b0;
      haltCyc = 0;
      @(negedge clk);
      programSelect = sel;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (cyc < 400) begin
         if (halted) begin
            sawHalt = 1'b1;
            haltCyc = cyc;
            break;
         end
         if (bus.execValid)
            gotExecSig = gotExecSig * 33 + {16'(cyc), bus.opcode, bus.fieldA, bus.fieldB, bus.fieldC};
         if (running && cyc[0]) gotFetchSig = gotFetchSig * 33 + 32'(bus.address);
         if (noisy) begin
            programSelect = 8'($urandom);
            start = 1'($urandom);
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      programSelect = sel;
   endtask

   task automatic clear_page(input int p);
      for (int i = 0; i < 256; i++) mem[p][i] = 16'h0000;
   endtask

   task automatic test_reset;
      #1;
      total++; if ({running, halted, fault, bus.execValid} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {running, halted, fault, bus.execValid}); end
      total++; if ({bus.address, bus.selectOut, instrCount} !== 32'd0) begin bad++; $display("FAIL reset_regs got=%h exp=0", {bus.address, bus.selectOut, instrCount}); end
      total++; if ({bus.opcode, bus.fieldA, bus.fieldB, bus.fieldC} !== 16'h0000) begin bad++; $display("FAIL reset_ir got=%h exp=0000", {bus.opcode, bus.fieldA, bus.fieldB, bus.fieldC}); end
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      total++; if ({running, halted} !== 2'b00) begin bad++; $display("FAIL reset_idle_wait got=%b exp=00", {running, halted}); end
   endtask

   task automatic test_basic;
      clear_page(0);
      mem[0][0] = 16'h2001; mem[0][1] = 16'h2F10; mem[0][2] = 16'h1234; mem[0][3] = 16'hE000;
      run_prog(8'h04, 1'b1);
      total++; if (!sawHalt || haltCyc != expCycles) begin bad++; $display("FAIL basic_halt_cycle got=%0d exp=%0d", haltCyc, expCycles); end
      total++; if (instrCount !== 16'(expCount) || expCount != 4) begin bad++; $display("FAIL basic_count got=%0d exp=4", instrCount); end
      total++; if (bus.address !== 8'd3 || fault !== 1'b0) begin bad++; $display("FAIL basic_pc_fault got=%0d/%b exp=3/0", bus.address, fault); end
      total++; if (gotExecSig !== expExecSig) begin bad++; $display("FAIL basic_exec_seq got=%h exp=%h", gotExecSig, expExecSig); end
      total++; if (bus.selectOut !== 8'h04) begin bad++; $display("FAIL basic_select_held got=%h exp=04", bus.selectOut); end
   endtask

   task automatic test_jump;
      clear_page(1);
      mem[1][0] = 16'h1000; mem[1][1] = 16'hD003; mem[1][2] = 16'h3333; mem[1][3] = 16'hE000;
      run_prog(8'h01, 1'b0);
      total++; if (gotFetchSig !== expFetchSig) begin bad++; $display("FAIL jump_fetch_seq got=%h exp=%h", gotFetchSig, expFetchSig); end
      total++; if (gotExecSig !== expExecSig) begin bad++; $display("FAIL jump_exec_seq got=%h exp=%h", gotExecSig, expExecSig); end
      total++; if (instrCount !== 16'd3 || bus.address !== 8'd3) begin bad++; $display("FAIL jump_count_pc got=%0d/%0d exp=3/3", instrCount, bus.address); end
   endtask

   task automatic test_cond;
      clear_page(2);
      mem[2][0] = 16'hF004; mem[2][1] = 16'hE000;
      regs[4] = 8'd5;
      run_prog(8'h02, 1'b0);
      total++; if (instrCount !== 16'd2 || bus.address !== 8'd1 || fault !== 1'b0) begin bad++; $display("FAIL cond_taken got=%0d/%0d/%b exp=2/1/0", instrCount, bus.address, fault); end
      total++; if (gotExecSig !== 32'd0) begin bad++; $display("FAIL cond_no_exec got=%h exp=0", gotExecSig); end
      regs[4] = 8'd0;
      run_prog(8'h02, 1'b0);
      total++; if ({halted, fault} !== 2'b10 || instrCount !== 16'd1 || bus.address !== 8'd0) begin bad++; $display("FAIL cond_halt got=%b/%0d/%0d exp=10/1/0", {halted, fault}, instrCount, bus.address); end
   endtask

   task automatic test_overrun;
      clear_page(3);
      mem[3][0] = 16'hD0FF;
      run_prog(8'h03, 1'b0);
      total++; if ({halted, fault} !== 2'b11 || instrCount !== 16'd1) begin bad++; $display("FAIL jump_overrun got=%b/%0d exp=11/1", {halted, fault}, instrCount); end
      mem[3][0] = 16'hD07F; mem[3][127] = 16'h1111;
      run_prog(8'h03, 1'b0);
      total++; if ({halted, fault} !== 2'b11 || bus.address !== 8'd127 || instrCount !== 16'd2) begin bad++; $display("FAIL inc_overrun got=%b/%0d/%0d exp=11/127/2", {halted, fault}, bus.address, instrCount); end
      total++; if (gotExecSig !== expExecSig) begin bad++; $display("FAIL inc_overrun_exec got=%h exp=%h", gotExecSig, expExecSig); end
      mem[3][0] = 16'hE000;
      run_prog(8'h03, 1'b0);
      total++; if (fault !== 1'b0 || bus.address !== 8'd0 || instrCount !== 16'd1) begin bad++; $display("FAIL restart_clear got=%b/%0d/%0d exp=0/0/1", fault, bus.address, instrCount); end
   endtask

   task automatic test_step_limit;
      clear_page(0);
      mem[0][0] = 16'hD000;
      run_prog(8'h00, 1'b0);
      total++; if ({halted, fault} !== 2'b11 || instrCount !== 16'(STEPS)) begin bad++; $display("FAIL step_limit got=%b/%0d exp=11/%0d", {halted, fault}, instrCount, STEPS); end
      total++; if (!sawHalt || haltCyc != 2 * STEPS + 1) begin bad++; $display("FAIL step_limit_cycle got=%0d exp=%0d", haltCyc, 2 * STEPS + 1); end
   endtask

   task automatic test_abort;
      clear_page(2);
      mem[2][0] = 16'h4223;
      @(negedge clk);
      programSelect = 8'h02;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      reset = 1'b1;
      #1;
      total++; if ({running, halted, fault, bus.execValid} !== 4'b0000) begin bad++; $display("FAIL abort_flags got=%b exp=0000", {running, halted, fault, bus.execValid}); end
      total++; if ({bus.address, bus.selectOut, instrCount, bus.opcode, bus.fieldA, bus.fieldB, bus.fieldC} !== 48'd0) begin bad++; $display("FAIL abort_regs got=%h exp=0", {bus.address, bus.selectOut, instrCount, bus.opcode, bus.fieldA, bus.fieldB, bus.fieldC}); end
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      total++; if ({running, halted, bus.execValid} !== 3'b000) begin bad++; $display("FAIL abort_idle got=%b exp=000", {running, halted, bus.execValid}); end
   endtask

   task automatic test_back_to_back;
      logic [7:0]  sel;
      logic [15:0] ins;
      for (int n = 0; n < 20; n++) begin
         sel = 8'($urandom);
         for (int i = 0; i < 256; i++) begin
            ins = 16'($urandom);
            if (ins[15:12] == 4'hD && $urandom_range(0, 7) != 0) ins[7] = 1'b0;
            mem[sel[1:0]][i] = ins;
         end
         for (int r = 0; r < 16; r++) regs[r] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom);
         run_prog(sel, 1'b1);
         total++; if (!sawHalt || haltCyc != expCycles) begin bad++; $display("FAIL rnd%0d_halt_cycle got=%0d exp=%0d", n, haltCyc, expCycles); end
         total++; if (instrCount !== 16'(expCount) || fault !== expFault || bus.address !== expPc) begin bad++; $display("FAIL rnd%0d_state got=%0d/%b/%0d exp=%0d/%b/%0d", n, instrCount, fault, bus.address, expCount, expFault, expPc); end
         total++; if (gotExecSig !== expExecSig || gotFetchSig !== expFetchSig) begin bad++; $display("FAIL rnd%0d_seq got=%h/%h exp=%h/%h", n, gotExecSig, gotFetchSig, expExecSig, expFetchSig); end
         total++; if (bus.selectOut !== sel) begin bad++; $display("FAIL rnd%0d_select got=%h exp=%h", n, bus.selectOut, sel); end
      end
   endtask

   initial begin
      for (int p = 0; p < 4; p++) clear_page(p);
      for (int r = 0; r < 16; r++) regs[r] = 8'd0;
      test_reset();
      test_basic();
      test_jump();
      test_cond();
      test_overrun();
      test_step_limit();
      test_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
